// File: rtl/timer_cnt_core.sv
// ---------------------------------------------------------------------------
// timer_cnt_core
//
// Counter core of the ICTC timer. A CNT_SIZE-bit counter is written and
// controlled through DATA_SIZE-bit register words coming from the APB decode.
// It provides a 4-bit prescaler, up/down counting, debug halt, N_CMP compare
// channels and an overflow/underflow flag, with sticky status bits and one
// level interrupt.
//
// Register map (word addresses):
//   0x00        CTRL   [0] timer_en [1] div_en [2] dir [11:8] div_val
//                      [16] halt_req, all other bits read 0
//   0x01        INT_ST write-1-to-clear
//   0x02        INT_EN
//   0x04+w      CNT word w          (w = 0..K-1, word 0 least significant)
//   0x08+4*i+w  CMP channel i word w
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en             register write strobe, one cycle per write
//   wr_addr, wdata    word address and write data
//   dbg_mode          CPU debug state
//   ctrl              CTRL register
//   cnt               counter value
//   cmp               compare registers, channel i at [i*CNT_SIZE +: CNT_SIZE]
//   int_en, int_st    interrupt enables / sticky status
//                     (bit N_CMP = overflow/underflow)
//   irq               |(int_st & int_en)
//   halted            dbg_mode && halt_req && timer_en
// ---------------------------------------------------------------------------

// One compare channel: a CNT_SIZE-bit register written word by word, plus
// an equality test against the live counter value.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (register -> all-ones)
//   wr         write strobe already decoded for this channel
//   word_sel   word index within the channel
//   wdata      write data
//   cnt        registered counter value
//   cmp        compare register
//   match      cnt == cmp, combinational from registers
module timer_cmp_ch #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [1:0]           word_sel,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [CNT_SIZE-1:0]  cnt,
    output logic [CNT_SIZE-1:0]  cmp,
    output logic                 match
);
    localparam int K = CNT_SIZE / DATA_SIZE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= '1;
        end else if (wr) begin
            for (int w = 0; w < K; w++) begin
                if (int'(word_sel) == w) begin
                    cmp[w*DATA_SIZE +: DATA_SIZE] <= wdata;
                end
            end
        end
    end

    assign match = (cnt == cmp);
endmodule

module timer_cnt_core #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = 64,
    parameter int N_CMP     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [5:0]                wr_addr,
    input  logic [DATA_SIZE-1:0]      wdata,
    input  logic                      dbg_mode,
    output logic [DATA_SIZE-1:0]      ctrl,
    output logic [CNT_SIZE-1:0]       cnt,
    output logic [N_CMP*CNT_SIZE-1:0] cmp,
    output logic [N_CMP:0]            int_en,
    output logic [N_CMP:0]            int_st,
    output logic                      irq,
    output logic                      halted
);
    localparam int K = CNT_SIZE / DATA_SIZE;

    // Only the implemented CTRL fields are stored; everything else reads 0.
    localparam logic [DATA_SIZE-1:0] CTRL_MASK = DATA_SIZE'(32'h0001_0F07);
    localparam logic [CNT_SIZE-1:0]  CNT_ONE   = CNT_SIZE'(1);

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [1:0] word_sel;
    logic       word_ok;
    logic       wr_ctrl;
    logic       wr_ist;
    logic       wr_ien;
    logic       wr_cnt;

    assign word_sel = wr_addr[1:0];
    // Word slots beyond K inside a 4-word group are holes in the map.
    assign word_ok  = ({1'b0, word_sel} < 3'(K));
    assign wr_ctrl  = wr_en && (wr_addr == 6'h00);
    assign wr_ist   = wr_en && (wr_addr == 6'h01);
    assign wr_ien   = wr_en && (wr_addr == 6'h02);
    assign wr_cnt   = wr_en && (wr_addr[5:2] == 4'h1) && word_ok;

    // ---------------------------------------------------------------------
    // CTRL fields
    // ---------------------------------------------------------------------
    logic       timer_en;
    logic       div_en;
    logic       dir;
    logic [3:0] div_val;
    logic       halt_req;

    assign timer_en = ctrl[0];
    assign div_en   = ctrl[1];
    assign dir      = ctrl[2];
    assign div_val  = ctrl[11:8];
    assign halt_req = ctrl[16];

    assign halted   = dbg_mode && halt_req && timer_en;

    // ---------------------------------------------------------------------
    // Control / enable registers
    // ---------------------------------------------------------------------
    logic timer_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl       <= '0;
            int_en     <= '0;
            timer_en_d <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl   <= wdata & CTRL_MASK;
            if (wr_ien)  int_en <= wdata[N_CMP:0];
            timer_en_d <= timer_en;
        end
    end

    // ---------------------------------------------------------------------
    // Prescaler: counts 0..div_val, ticking on the terminal value. Any CTRL
    // write restarts it so a new divider always begins a full period.
    // ---------------------------------------------------------------------
    logic [3:0] presc;
    logic       tick;

    always_ff @(posedge clk) begin
        if (rst || wr_ctrl || !timer_en || !div_en) begin
            presc <= '0;
        end else if (!halted) begin
            presc <= (presc == div_val) ? 4'd0 : presc + 4'd1;
        end
    end

    assign tick = timer_en && !halted && (div_en ? (presc == div_val) : 1'b1);

    // ---------------------------------------------------------------------
    // Counter next state
    // ---------------------------------------------------------------------
    logic [CNT_SIZE-1:0] cnt_nxt;
    logic                wrap;

    always_comb begin
        cnt_nxt = cnt;
        wrap    = 1'b0;
        if (timer_en_d && !timer_en) begin
            // Falling edge of timer_en: the count restarts from zero.
            cnt_nxt = '0;
        end else if (wr_cnt) begin
            // A word write pre-empts the tick for this cycle; other words hold.
            for (int w = 0; w < K; w++) begin
                if (int'(word_sel) == w) begin
                    cnt_nxt[w*DATA_SIZE +: DATA_SIZE] = wdata;
                end
            end
        end else if (tick) begin
            if (dir) begin
                cnt_nxt = cnt - CNT_ONE;
                wrap    = (cnt == '0);
            end else begin
                cnt_nxt = cnt + CNT_ONE;
                wrap    = &cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Compare channels
    // ---------------------------------------------------------------------
    logic [N_CMP-1:0] match;

    for (genvar i = 0; i < N_CMP; i++) begin : g_cmp
        logic wr_cmp;

        assign wr_cmp = wr_en && (wr_addr[5:2] == 4'(2 + i)) && word_ok;

        timer_cmp_ch #(
            .DATA_SIZE (DATA_SIZE),
            .CNT_SIZE  (CNT_SIZE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_cmp),
            .word_sel (word_sel),
            .wdata    (wdata),
            .cnt      (cnt),
            .cmp      (cmp[i*CNT_SIZE +: CNT_SIZE]),
            .match    (match[i])
        );
    end

    // ---------------------------------------------------------------------
    // Sticky status: set events win over a same-cycle write-1-to-clear, so a
    // match that is still true cannot be cleared away.
    // ---------------------------------------------------------------------
    logic [N_CMP:0] st_set;
    logic [N_CMP:0] st_clr;

    assign st_set = {wrap, match};
    assign st_clr = wr_ist ? wdata[N_CMP:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_st <= '0;
        end else begin
            int_st <= (int_st & ~st_clr) | st_set;
        end
    end

    assign irq = |(int_st & int_en);
endmodule

// File: tb/tb_timer_cnt_core.sv
module tb_timer_cnt_core;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [31:0]  wdata;
    logic         dbg_mode;
    logic [31:0]  ctrl;
    logic [63:0]  cnt;
    logic [127:0] cmp;
    logic [2:0]   int_en;
    logic [2:0]   int_st;
    logic         irq;
    logic         halted;

    timer_cnt_core #(.DATA_SIZE(32), .CNT_SIZE(64), .N_CMP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wdata    (wdata),
        .dbg_mode (dbg_mode),
        .ctrl     (ctrl),
        .cnt      (cnt),
        .cmp      (cmp),
        .int_en   (int_en),
        .int_st   (int_st),
        .irq      (irq),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        dbg;
        logic [63:0] cnt;
        logic [31:0] ctrl;
        logic [2:0]  st;
        logic        irq;
        logic        halt;
    } vec_t;

    typedef struct {
        logic [63:0] cnt;
        logic [31:0] ctrl;
        logic [2:0]  st;
        logic        irq;
        logic        halt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic w, input logic [5:0] a, input logic [31:0] d, input logic dg,
                       input logic [63:0] c, input logic [31:0] ct, input logic [2:0] s,
                       input logic i, input logic h);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.dbg = dg;
        v.cnt = c; v.ctrl = ct; v.st = s; v.irq = i; v.halt = h;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare the
    // registered outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic dg, input exp_t e, input string tag);
        exp_t x;
        sb.push_back(e);
        rst = r; wr_en = w; wr_addr = a; wdata = d; dbg_mode = dg;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL %s.sb: got empty scoreboard expected one entry", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, ".cnt"},    128'(cnt),    128'(x.cnt));
            chk({tag, ".ctrl"},   128'(ctrl),   128'(x.ctrl));
            chk({tag, ".int_st"}, 128'(int_st), 128'(x.st));
            chk({tag, ".irq"},    128'(irq),    128'(x.irq));
            chk({tag, ".halted"}, 128'(halted), 128'(x.halt));
        end
    endtask

    task automatic hs(input logic r, input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic dg, input logic [63:0] c, input logic [31:0] ct,
                      input logic [2:0] s, input logic i, input logic h, input string tag);
        exp_t e;
        e.cnt = c; e.ctrl = ct; e.st = s; e.irq = i; e.halt = h;
        step(r, w, a, d, dg, e, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        // Up count, no divider, then disable.
        add(1, 6'h00, 32'h1, 0, 64'd0, 32'h1, 3'd0, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 6'h00, 32'h0, 0, 64'(i), 32'h1, 3'd0, 0, 0);
        add(1, 6'h00, 32'h0, 0, 64'd11, 32'h0, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'd0,  32'h0, 3'd0, 0, 0);
        // Up wrap from all-ones; cnt==cmp(all-ones) also flags both channels.
        add(1, 6'h04, 32'hFFFF_FFFF, 0, 64'h0000_0000_FFFF_FFFF, 32'h0, 3'd0, 0, 0);
        add(1, 6'h05, 32'hFFFF_FFFF, 0, ALL1,  32'h0, 3'd0, 0, 0);
        add(1, 6'h02, 32'h4,         0, ALL1,  32'h0, 3'd3, 0, 0);
        add(1, 6'h00, 32'h1,         0, ALL1,  32'h1, 3'd3, 0, 0);
        add(0, 6'h00, 32'h0,         0, 64'd0, 32'h1, 3'd7, 1, 0);
        add(1, 6'h01, 32'h4,         0, 64'd1, 32'h1, 3'd3, 0, 0);
        add(1, 6'h01, 32'h3,         0, 64'd2, 32'h1, 3'd0, 0, 0);
        add(1, 6'h00, 32'h0,         0, 64'd3, 32'h0, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0,         0, 64'd0, 32'h0, 3'd0, 0, 0);
        // Divider 3: one step every 4 cycles.
        add(1, 6'h00, 32'h303, 0, 64'd0, 32'h303, 3'd0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 6'h00, 32'h0, 0, 64'(i / 4), 32'h303, 3'd0, 0, 0);
        // Down count from 0 wraps to all-ones.
        add(1, 6'h04, 32'h0,   0, 64'd0, 32'h303, 3'd0, 0, 0);
        add(1, 6'h00, 32'h305, 0, 64'd0, 32'h305, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0,   0, ALL1,  32'h305, 3'd4, 1, 0);
        add(0, 6'h00, 32'h0,   0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h305, 3'd7, 1, 0);
        add(1, 6'h01, 32'h7,   0, 64'hFFFF_FFFF_FFFF_FFFD, 32'h305, 3'd0, 0, 0);
        add(1, 6'h00, 32'h0,   0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0,   3'd0, 0, 0);
        add(0, 6'h00, 32'h0,   0, 64'd0, 32'h0, 3'd0, 0, 0);
        // Compare channels: cmp0=5, cmp1=8.
        add(1, 6'h08, 32'h5, 0, 64'd0, 32'h0, 3'd0, 0, 0);
        add(1, 6'h09, 32'h0, 0, 64'd0, 32'h0, 3'd0, 0, 0);
        add(1, 6'h0C, 32'h8, 0, 64'd0, 32'h0, 3'd0, 0, 0);
        add(1, 6'h0D, 32'h0, 0, 64'd0, 32'h0, 3'd0, 0, 0);
        add(1, 6'h02, 32'h3, 0, 64'd0, 32'h0, 3'd0, 0, 0);
        add(1, 6'h00, 32'h1, 0, 64'd0, 32'h1, 3'd0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            logic [2:0] s;
            s = {1'b0, (i >= 9), (i >= 6)};
            add(0, 6'h00, 32'h0, 0, 64'(i), 32'h1, s, (s != 3'd0), 0);
        end
        add(1, 6'h01, 32'h3, 0, 64'd10, 32'h1, 3'd0, 0, 0);
        add(1, 6'h00, 32'h0, 0, 64'd11, 32'h0, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'd0,  32'h0, 3'd0, 0, 0);
        // Held match re-sets the flag; W1C during the match loses.
        add(1, 6'h04, 32'h5, 0, 64'd5, 32'h0, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'd5, 32'h0, 3'd1, 1, 0);
        add(1, 6'h01, 32'h1, 0, 64'd5, 32'h0, 3'd1, 1, 0);
        add(1, 6'h04, 32'h6, 0, 64'd6, 32'h0, 3'd1, 1, 0);
        add(1, 6'h01, 32'h1, 0, 64'd6, 32'h0, 3'd0, 0, 0);
        // CNT word write in a ticking cycle: word taken, no increment.
        add(1, 6'h00, 32'h1, 0, 64'd6, 32'h1, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'd7, 32'h1, 3'd0, 0, 0);
        add(1, 6'h05, 32'h1, 0, 64'h1_0000_0007, 32'h1, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'h1_0000_0008, 32'h1, 3'd0, 0, 0);
        add(1, 6'h00, 32'h0, 0, 64'h1_0000_0009, 32'h0, 3'd0, 0, 0);
        add(0, 6'h00, 32'h0, 0, 64'd0, 32'h0, 3'd0, 0, 0);

        // ---------------- reset state ----------------
        hs(1, 0, 6'h00, 32'h0, 0, 64'd0, 32'h0, 3'd0, 0, 0, "reset");
        chk("reset.cmp",    cmp,           {ALL1, ALL1});
        chk("reset.int_en", 128'(int_en),  128'd0);

        // ---------------- table ----------------
        for (int k = 0; k < tbl.size(); k++) begin
            exp_t e;
            e.cnt = tbl[k].cnt; e.ctrl = tbl[k].ctrl; e.st = tbl[k].st;
            e.irq = tbl[k].irq; e.halt = tbl[k].halt;
            step(0, tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].dbg, e, $sformatf("vec%0d", k));
        end
        chk("tbl.cmp",    cmp,          {64'd8, 64'd5});
        chk("tbl.int_en", 128'(int_en), 128'd3);

        // ---------------- debug halt, divider 1 ----------------
        // Unimplemented CTRL bits in the write are dropped on readback.
        hs(0, 1, 6'h00, 32'hFFF1_F1F3, 0, 64'd0, 32'h10103, 3'd0, 0, 0, "h0");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd0, 32'h10103, 3'd0, 0, 0, "h1");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd1, 32'h10103, 3'd0, 0, 0, "h2");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd1, 32'h10103, 3'd0, 0, 0, "h3");
        hs(0, 0, 6'h00, 32'h0, 1, 64'd1, 32'h10103, 3'd0, 0, 1, "h4");
        hs(0, 0, 6'h00, 32'h0, 1, 64'd1, 32'h10103, 3'd0, 0, 1, "h5");
        hs(0, 1, 6'h02, 32'h7, 1, 64'd1, 32'h10103, 3'd0, 0, 1, "h6");
        hs(0, 0, 6'h00, 32'h0, 1, 64'd1, 32'h10103, 3'd0, 0, 1, "h7");
        hs(0, 0, 6'h00, 32'h0, 1, 64'd1, 32'h10103, 3'd0, 0, 1, "h8");
        // Prescaler was frozen at its terminal value, so the tick comes at once.
        hs(0, 0, 6'h00, 32'h0, 0, 64'd2, 32'h10103, 3'd0, 0, 0, "h9");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd2, 32'h10103, 3'd0, 0, 0, "h10");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd3, 32'h10103, 3'd0, 0, 0, "h11");
        chk("halt.int_en", 128'(int_en), 128'd7);

        // ---------------- reset mid-count ----------------
        hs(0, 1, 6'h04, 32'h5, 0, 64'd5, 32'h10103, 3'd0, 0, 0, "r0");
        hs(0, 0, 6'h00, 32'h0, 0, 64'd6, 32'h10103, 3'd1, 1, 0, "r1");
        hs(1, 1, 6'h00, 32'h1, 1, 64'd0, 32'h0, 3'd0, 0, 0, "r2");
        chk("rst.cmp",    cmp,          {ALL1, ALL1});
        chk("rst.int_en", 128'(int_en), 128'd0);
        hs(0, 0, 6'h00, 32'h0, 0, 64'd0, 32'h0, 3'd0, 0, 0, "r3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/timer_cnt_core.md
# timer_cnt_core

Parametrised timer counter core for the ICTC timer: a CNT_SIZE-bit counter written and controlled through DATA_SIZE-bit register words, with a programmable prescaler, up/down counting, debug halt, N_CMP compare channels and an overflow flag. Sticky interrupt status and a single level interrupt are produced. It sits between the APB register decode (write strobe, word address, wdata) and the interrupt output of the timer.

## Interface
- DATA_SIZE, 32, register word width; CNT_SIZE must equal K*DATA_SIZE, K in 1..4
- CNT_SIZE, 64, counter width
- N_CMP, 2, compare channels, 1..4
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  register write strobe, one cycle per write
- wr_addr  input  6  word address
- wdata  input  DATA_SIZE  write data
- dbg_mode  input  1  CPU debug state
- ctrl  output  DATA_SIZE  CTRL register
- cnt  output  CNT_SIZE  counter value
- cmp  output  N_CMP*CNT_SIZE  compare registers, channel i at [i*CNT_SIZE +: CNT_SIZE]
- int_en  output  N_CMP+1  interrupt enables
- int_st  output  N_CMP+1  sticky status; bits [N_CMP-1:0] compare match, bit N_CMP overflow/underflow
- irq  output  1  |(int_st & int_en), combinational from registers
- halted  output  1  dbg_mode && ctrl[16] && ctrl[0]

## Operation
- Map: 0x00 CTRL, 0x01 INT_ST (write-1-to-clear), 0x02 INT_EN, 0x04+w CNT word w, 0x08+4*i+w CMP channel i word w (w = 0..K-1, word 0 least significant). Writes to other addresses are ignored.
- CTRL: [0] timer_en, [1] div_en, [2] dir (0 up, 1 down), [11:8] div_val, [16] halt_req; other bits always read 0.
- Reset: ctrl 0, cnt 0, every cmp all-ones, int_en 0, int_st 0, prescaler 0; so irq 0 and halted 0.
- Prescaler (4-bit): increments when timer_en && div_en && !halted. When it equals div_val it returns to 0 and issues a tick. It is cleared while timer_en=0 or div_en=0, and on any CTRL write.
- tick = timer_en && !halted && (div_en ? prescaler==div_val : 1).
- Counter next-state priority: rst; then timer_en falling edge (registered timer_en_d=1, ctrl[0]=0) clears cnt to 0; then a CNT word write replaces only that word; then tick counts up (+1) or down (-1) by dir; otherwise cnt holds.
- Arithmetic is modulo 2^CNT_SIZE. Up from all-ones wraps to 0; down from 0 wraps to all-ones. Either wrap sets int_st[N_CMP].
- Compare: int_st[i] is set when the registered cnt == cmp[i]. Evaluation runs every cycle, whether or not counting. Equality held over several cycles re-sets the flag each cycle.
- INT_ST write: each 1 bit clears. A set event in the same cycle wins (the bit stays 1).
- A CNT write in a cycle that would tick: the written word is taken, other words hold, and no increment occurs that cycle.
- halted freezes cnt and the prescaler; register writes are still accepted.

## Timing
- Any write at edge N is visible on its output after edge N. irq follows int_st/int_en with no extra cycle.
- Enable with div_en=0: first cnt change at the first edge after the edge that wrote timer_en=1.
- With div_en=1 and div_val=D: cnt steps once every D+1 cycles. The first step comes D+1 edges after enable.
- Match latency: cnt reaches cmp[i] at edge N, int_st[i] rises at edge N+1.
- Disable: CTRL write of timer_en=0 at edge N; cnt=0 after edge N+1.
- rst mid-count restores all reset values at that edge, regardless of wr_en.

## Test plan
- Reset, then CTRL=0x1, dir up, no divider, 10 cycles -> cnt steps 0→10, one step per cycle; int_st=0.
- CNT word0=0xFFFFFFFF, word1=0xFFFFFFFF, int_en=0x4, CTRL=0x1 -> cnt wraps to 0 and int_st[2]=1 the next cycle, irq=1. Write INT_ST=0x4 -> irq=0.
- CTRL=0x303 (div_en, div_val=3) -> cnt increments every 4 cycles; CTRL=0x305 (dir down) from cnt=0 -> next tick cnt=all-ones, int_st[2] set.
- cmp0=5, cmp1=8, int_en=0x3, count up from 0 -> int_st[0] rises one cycle after cnt=5, int_st[1] one cycle after cnt=8. W1C of bit0 while cnt==cmp0 leaves bit0 at 1.
- Counting, CTRL halt_req=1, dbg_mode=1 for 5 cycles -> cnt and prescaler frozen, halted=1; dbg_mode=0 -> counting resumes from the frozen value.
- Counting at cnt=100, CTRL=0 -> cnt=0 two edges later. Separately, rst asserted mid-count -> all outputs at reset values after the edge.
